// File: rtl/bist_tpg_sisr.sv
// BIST wrapper stage: exhaustive 32-pattern generator (all-zero + 5-bit LFSR)
// feeding x1..x5, with a 16-bit serial-input signature register compacting z.
module bist_tpg_sisr #(
  parameter logic [15:0] SIG_POLY = 16'h1021,
  parameter logic [15:0] GOLDEN   = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        z,
  output logic        x1,
  output logic        x2,
  output logic        x3,
  output logic        x4,
  output logic        x5,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [4:0]  pat;
  logic [4:0]  lfsr;
  logic [15:0] sig;
  logic        fb;

  assign fb = sig[15] ^ z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      pat   <= '0;
      lfsr  <= 5'b00001;
      sig   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state <= S_RUN;
            cnt   <= '0;
            pat   <= '0;
            lfsr  <= 5'b00001;
            sig   <= '0;
          end
        end
        S_RUN: begin
          sig  <= {sig[14:0], 1'b0} ^ (fb ? SIG_POLY : 16'h0000);
          cnt  <= cnt + 5'd1;
          lfsr <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
          // Last compaction edge: drop the pattern bus to zero alongside the DONE entry
          if (cnt == 5'd31) begin
            state <= S_DONE;
            pat   <= '0;
          end else begin
            pat <= lfsr;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign {x1, x2, x3, x4, x5} = pat;
  assign busy      = (state == S_RUN);
  assign done      = (state == S_DONE);
  assign pass      = (state == S_DONE) && (sig == GOLDEN);
  assign signature = sig;

endmodule

// File: tb/tb_bist_tpg_sisr.sv
// Self-checking bench for bist_tpg_sisr: behavioural pattern/CRC model, vector
// tables for the documented pattern and signature values, control corner cases.
module tb_bist_tpg_sisr;

  localparam logic [15:0] POLY = 16'h1021;

  // Reference: shift-register division of the z stream by x^16+x^12+x^5+1
  function automatic logic [15:0] crc_step(input logic [15:0] s, input logic b);
    int unsigned v;
    v = 32'(s) * 2;
    if ((s[15] ^ b) == 1'b1) v = v ^ 32'(POLY);
    return 16'(v % 65536);
  endfunction

  // Pattern k of the exhaustive sequence: 0, then successive states of x^5+x^3+1
  function automatic logic [4:0] pattern_of(input int k);
    int unsigned s;
    int unsigned nb;
    if (k == 0) return 5'd0;
    s = 1;
    for (int i = 1; i < k; i++) begin
      nb = ((s / 16) % 2) ^ ((s / 4) % 2);
      s  = ((s * 2) % 32) + nb;
    end
    return 5'(s);
  endfunction

  // Stand-in CUT with inputs x1..x5 = p[4]..p[0]
  function automatic logic cut_z(input logic [4:0] p);
    return (p[4] & p[3]) | (~p[2] & p[1]) | (p[3] & p[0]);
  endfunction

  function automatic logic [15:0] golden_cut();
    logic [15:0] s;
    s = 16'h0000;
    for (int k = 0; k < 32; k++) s = crc_step(s, cut_z(pattern_of(k)));
    return s;
  endfunction

  localparam logic [15:0] G_CUT = golden_cut();

  logic clk = 1'b0;
  logic rst, start, z;
  logic a_x1, a_x2, a_x3, a_x4, a_x5, a_busy, a_done, a_pass;
  logic b_x1, b_x2, b_x3, b_x4, b_x5, b_busy, b_done, b_pass;
  logic [15:0] a_sig, b_sig;

  always #5 clk = ~clk;

  bist_tpg_sisr #(.SIG_POLY(16'h1021), .GOLDEN(16'h0000)) dut0 (
    .clk(clk), .rst(rst), .start(start), .z(z),
    .x1(a_x1), .x2(a_x2), .x3(a_x3), .x4(a_x4), .x5(a_x5),
    .busy(a_busy), .done(a_done), .pass(a_pass), .signature(a_sig));

  bist_tpg_sisr #(.SIG_POLY(16'h1021), .GOLDEN(G_CUT)) dut1 (
    .clk(clk), .rst(rst), .start(start), .z(z),
    .x1(b_x1), .x2(b_x2), .x3(b_x3), .x4(b_x4), .x5(b_x5),
    .busy(b_busy), .done(b_done), .pass(b_pass), .signature(b_sig));

  int tests = 0;
  int fails = 0;
  logic [4:0]  cap_x [32];
  logic [15:0] cap_sig [33];
  logic [4:0]  pats [32];

  typedef struct { int k; logic [4:0] x; } pat_vec_t;
  typedef struct { int k; logic [15:0] sig; } sig_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] xa();
    return {a_x1, a_x2, a_x3, a_x4, a_x5};
  endfunction

  // mode: 0 z=0, 1 z=1, 2 CUT, 3 random. Called at a negedge in IDLE/DONE.
  task automatic run_check(input int mode, input bit hold, output logic [15:0] fin);
    logic [15:0] e;
    int busy_cnt;
    e = 16'h0000;
    busy_cnt = 0;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      cap_x[k] = xa();
      cap_sig[k] = a_sig;
      if (a_busy) busy_cnt++;
      chk("x_pattern", 32'(xa()), 32'(pats[k]));
      chk("sig_run", 32'(a_sig), 32'(e));
      chk("done_low_in_run", 32'(a_done | b_done), 32'd0);
      case (mode)
        0: z = 1'b0;
        1: z = 1'b1;
        2: z = cut_z(pats[k]);
        default: z = 1'($urandom);
      endcase
      e = crc_step(e, z);
    end
    @(negedge clk);
    cap_sig[32] = a_sig;
    chk("busy_cycles", 32'(busy_cnt), 32'd32);
    chk("done_after_E32", 32'({a_busy, a_done, b_done}), 32'b011);
    chk("sig_final", 32'(a_sig), 32'(e));
    chk("sig_final_b", 32'(b_sig), 32'(e));
    chk("x_zero_done", 32'(xa()), 32'd0);
    chk("pass_g0", 32'(a_pass), 32'(e == 16'h0000));
    chk("pass_gcut", 32'(b_pass), 32'(e == G_CUT));
    start = 1'b0;
    fin = e;
  endtask

  task automatic chk_cleared(input string name);
    chk(name, {8'(xa()), 2'(a_busy), 2'(a_done), 2'(a_pass), a_sig}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pat_vec_t pv [7];
    sig_vec_t sv [2];
    logic [15:0] f1, f2;
    logic [31:0] seen;
    int done_seen;

    pv = '{'{0, 5'b00000}, '{1, 5'b00001}, '{2, 5'b00010}, '{3, 5'b00100},
           '{4, 5'b01001}, '{5, 5'b10010}, '{6, 5'b00101}};
    sv = '{'{1, 16'h1021}, '{2, 16'h3063}};
    for (int k = 0; k < 32; k++) pats[k] = pattern_of(k);

    rst = 1'b1; start = 1'b0; z = 1'b0;
    #12 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_cleared("idle_after_reset");
    end

    // z=0 run: pattern order, distinctness, pass with GOLDEN=0
    run_check(0, 1'b0, f1);
    for (int i = 0; i < 7; i++) chk("pattern_table", 32'(cap_x[pv[i].k]), 32'(pv[i].x));
    seen = '0;
    for (int k = 0; k < 32; k++) seen[cap_x[k]] = 1'b1;
    chk("all_patterns_distinct", seen, 32'hFFFF_FFFF);
    chk("pass_z0", 32'(a_pass), 32'd1);

    // z=1 run: documented signature values after E1, E2
    run_check(1, 1'b0, f1);
    for (int i = 0; i < 2; i++) chk("sig_table_z1", 32'(cap_sig[sv[i].k]), 32'(sv[i].sig));

    // Real CUT, then restart from DONE reproduces the signature
    run_check(2, 1'b0, f1);
    chk("pass_cut", 32'(b_pass), 32'd1);
    run_check(2, 1'b0, f2);
    chk("restart_same_sig", 32'(f2), 32'(f1));
    chk("restart_sig_golden", 32'(b_sig), 32'(G_CUT));

    // Stuck-at faults on z: pass follows the model comparison against GOLDEN
    run_check(0, 1'b0, f1);
    chk("stuck0_pass", 32'(b_pass), 32'(G_CUT == 16'h0000));
    run_check(1, 1'b0, f1);
    chk("stuck1_pass", 32'(b_pass), 32'(f1 == G_CUT));

    // start held high through RUN
    run_check(2, 1'b1, f1);
    @(negedge clk);
    chk("held_start_stays_done", 32'({a_busy, a_done}), 32'b01);

    // Random z streams
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(3, 0)) @(negedge clk);
      run_check(3, 1'b0, f1);
    end

    // Asynchronous reset mid-cycle clears outputs before the next edge
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_cleared("async_reset_mid_cycle");
    @(negedge clk) rst = 1'b0;

    // Reset at cnt=15: no done follows, then a full run
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (15) @(posedge clk);
    #3 rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (a_done || a_busy) done_seen++;
    end
    chk("no_done_after_reset", 32'(done_seen), 32'd0);
    chk_cleared("idle_after_abort");
    run_check(2, 1'b0, f1);
    chk("full_run_after_abort", 32'(b_pass), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
